// File: rtl/key_debounce_irq_ctrl.sv
// rtl/key_debounce_irq_ctrl.sv - Push-button synchroniser, debouncer and edge-capture IRQ slave
// Optional feature macro: RELEASE_EDGE_EN (also capture key releases in EDGE).
module key_debounce_irq_ctrl #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int               PAD_W    = 32 - NUM_KEYS;

  logic [NUM_KEYS-1:0] sync_a;
  logic [NUM_KEYS-1:0] sync_b;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] toggle;
  logic [NUM_KEYS-1:0] capture;
  logic [NUM_KEYS-1:0] edge_cap;
  logic [NUM_KEYS-1:0] edge_clr;
  logic [NUM_KEYS-1:0] irq_mask;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic                wr_en;
  logic                unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign pressed      = ~sync_b;
  assign unused_wdata = ^writedata[31:NUM_KEYS];

  // Two-flop synchroniser per key; released (1) is the safe reset level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  // A key flips when the new level is seen for the last cycle of the debounce window.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      toggle[i] = (pressed[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Events that set EDGE: presses only, or both directions when releases are captured.
  always_comb begin
`ifdef RELEASE_EDGE_EN
    capture = toggle;
`else
    capture = toggle & ~stable;
`endif
  end

  // Software clear mask for EDGE (write-one-to-clear at address 3).
  always_comb begin
    edge_clr = '0;
    if (wr_en && (address == 2'd3)) begin
      edge_clr = writedata[NUM_KEYS-1:0];
    end
  end

  // Debounce counters: count consecutive mismatching cycles, restart on any match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (pressed[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      stable <= stable ^ toggle;
    end
  end

  // Edge capture, mask register and level interrupt; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | capture;
      if (wr_en && (address == 2'd1)) begin
        irq_mask <= writedata[NUM_KEYS-1:0];
      end
      irq <= |(edge_cap & irq_mask);
    end
  end

  // Registered read mux, updated every cycle so data follows the address by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= {{PAD_W{1'b0}}, stable};
        2'd1:    readdata <= {{PAD_W{1'b0}}, irq_mask};
        2'd3:    readdata <= {{PAD_W{1'b0}}, edge_cap};
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_irq_ctrl.sv
// tb/tb_key_debounce_irq_ctrl.sv - Randomised, model-checked bench for key_debounce_irq_ctrl
module tb_key_debounce_irq_ctrl;

  localparam int NK = 2;
  localparam int DB = 8;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NK-1:0] key_n;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a key's level is accepted once the last DB synchronised
  // samples (raw pin delayed by two clocks) all disagree with the accepted level.
  logic [DB+1:0] samp [NK];
  logic [NK-1:0] m_stable;
  logic [NK-1:0] m_edge;
  logic [NK-1:0] m_mask;
  logic [31:0]   m_rd;
  logic          m_irq;

  key_debounce_irq_ctrl #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .key_n(key_n),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NK; k++) samp[k] = '0;
    m_stable = '0;
    m_edge   = '0;
    m_mask   = '0;
    m_rd     = '0;
    m_irq    = 1'b0;
  endtask

  task automatic m_step();
    logic [NK-1:0] flip;
    logic [NK-1:0] ev;
    logic [NK-1:0] clr;
    logic [DB-1:0] win;
    flip = '0;
    for (int k = 0; k < NK; k++) begin
      samp[k] = {samp[k][DB:0], ~key_n[k]};
      win = samp[k][DB+1:2];
      if (m_stable[k] ? (win == '0) : (win == '1)) flip[k] = 1'b1;
    end
    case (address)
      2'd0:    m_rd = 32'(m_stable);
      2'd1:    m_rd = 32'(m_mask);
      2'd3:    m_rd = 32'(m_edge);
      default: m_rd = 32'h0;
    endcase
    m_irq = |(m_edge & m_mask);
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[NK-1:0] : '0;
    ev = flip & ~m_stable;
`ifdef RELEASE_EDGE_EN
    ev = flip;
`endif
    m_edge = (m_edge & ~clr) | ev;
    if (chipselect && !write_n && address == 2'd1) m_mask = writedata[NK-1:0];
    m_stable = m_stable ^ flip;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("model_readdata", readdata, m_rd);
        check("model_irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    int run [NK];
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    key_n      = '1;
    tick();
    tick();
    sample();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    tick();
    reset_n = 1'b1;

    // Reset values at every register address
    address = 2'd0; tick(); sample(); check("rd_data_reset", readdata, 32'h0);
    address = 2'd1; tick(); sample(); check("rd_mask_reset", readdata, 32'h0);
    address = 2'd3; tick(); sample(); check("rd_edge_reset", readdata, 32'h0);
    check("irq_after_reset", 32'(irq), 32'h0);

    // Key 0 press: DATA becomes 1 on the 10th clock after the pin change
    address  = 2'd0;
    key_n[0] = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      sample();
      if (i == 10) check("data_before_latency", readdata, 32'h0);
      if (i == 11) check("data_after_latency", readdata, 32'h1);
    end
    address = 2'd3; tick(); sample();
    check("edge_key0_press", readdata, 32'h1);
    check("irq_masked", 32'(irq), 32'h0);

    // Key 1 glitch train never holds 8 cycles
    key_n[1] = 1'b0; repeat (5) tick();
    key_n[1] = 1'b1; repeat (2) tick();
    key_n[1] = 1'b0; repeat (5) tick();
    key_n[1] = 1'b1; repeat (12) tick();
    address = 2'd0; tick(); sample();
    check("glitch_data", readdata, 32'h1);
    address = 2'd3; tick(); sample();
    check("glitch_edge", readdata, 32'h1);

    // Unmask with pending event, then clear it
    wr(2'd1, 32'h3);
    sample(); check("irq_one_after_mask", 32'(irq), 32'h0);
    tick(); sample(); check("irq_two_after_mask", 32'(irq), 32'h1);
    wr(2'd3, 32'h1);
    sample(); check("irq_one_after_clear", 32'(irq), 32'h1);
    tick(); sample(); check("irq_two_after_clear", 32'(irq), 32'h0);
    check("edge_cleared", readdata, 32'h0);

    // Clear of bit 1 in the very cycle key 1 completes its debounce
    key_n[1] = 1'b0;
    repeat (9) tick();
    wr(2'd3, 32'h2);
    address = 2'd3; tick(); sample();
    check("set_wins_edge", readdata, 32'h2);
    check("set_wins_irq", 32'(irq), 32'h1);
    tick(); sample();
    check("irq_stays", 32'(irq), 32'h1);

    // Release key 0
    address  = 2'd3;
    key_n[0] = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      sample();
      if (i == 10) check("release_edge_before", readdata, 32'h2);
`ifdef RELEASE_EDGE_EN
      if (i == 11) check("release_edge_after", readdata, 32'h3);
`else
      if (i == 11) check("release_edge_after", readdata, 32'h2);
`endif
    end
    address = 2'd0; tick(); sample();
    check("release_data", readdata, 32'h2);

    key_n = '1;
    wr(2'd3, 32'h3);
    repeat (12) tick();

    // Randomised keys with bounce runs and random bus traffic, with one reset mid-run
    for (int k = 0; k < NK; k++) run[k] = $urandom_range(1, 14);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        run[k] = run[k] - 1;
        if (run[k] == 0) begin
          key_n[k] = ~key_n[k];
          run[k]   = $urandom_range(1, 14);
        end
      end
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if (c == 1500) reset_n = 1'b0;
      if (c == 1504) reset_n = 1'b1;
      tick();
    end

    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();
    sample();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
